// File: rtl/dsi_cfg_axil_responder_if.sv
// -----------------------------------------------------------------------------
// dsi_cfg_axil_responder_if
// AXI4-Lite bundle for the panel-configuration link (7-bit byte address,
// 32-bit data, no BRESP/RRESP since every response is OKAY).
//   awaddr/awvalid/awready : write address channel
//   wdata/wvalid/wready    : write data channel
//   bvalid/bready          : write response channel
//   araddr/arvalid/arready : read address channel
//   rdata/rvalid/rready    : read data channel
// Modports: master (config initiator), slave (responder).
// -----------------------------------------------------------------------------
interface dsi_cfg_axil_responder_if;
  logic [6:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [6:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/dsi_cfg_axil_responder.sv
// -----------------------------------------------------------------------------
// dsi_cfg_axil_responder
// AXI4-Lite slave for the panel-configuration link. Holds a CTRL register,
// a STATUS view, an IRQ_CLR strobe, four scratch registers and a command FIFO
// fed by writes to CMD_PUSH and drained by a downstream consumer.
// Ports:
//   i_fb_clk     clock
//   i_arstn      asynchronous active-low reset
//   axi          AXI4-Lite slave modport
//   o_ctrl       CTRL register contents
//   o_cmd_data   FIFO head word (0 when empty)
//   o_cmd_valid  FIFO not empty
//   i_cmd_ready  consumer pop strobe
//   o_irq        registered OVF & CTRL[0]
// -----------------------------------------------------------------------------
module dsi_cfg_axil_responder #(
  parameter int          FIFO_AW  = 4,
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic                          i_fb_clk,
  input  logic                          i_arstn,
  dsi_cfg_axil_responder_if.slave       axi,
  output logic [31:0]                   o_ctrl,
  output logic [31:0]                   o_cmd_data,
  output logic                          o_cmd_valid,
  input  logic                          i_cmd_ready,
  output logic                          o_irq
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
  localparam logic [FIFO_AW:0]   LVL_ONE   = 1;
  localparam logic [FIFO_AW:0]   LVL_FULL  = DEPTH[FIFO_AW:0];

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // ---------------------------------------------------------------- write FSM
  logic [1:0]  wstate_q, wstate_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        commit;
  logic [4:0]  c_addr;
  logic [31:0] c_data;

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    commit   = 1'b0;
    c_addr   = waddr_q;
    c_data   = wdata_q;
    case (wstate_q)
      W_IDLE: begin
        if (axi.awvalid && axi.wvalid) begin
          commit   = 1'b1;
          c_addr   = axi.awaddr[6:2];
          c_data   = axi.wdata;
          wstate_d = W_RESP;
        end else if (axi.awvalid) begin
          waddr_d  = axi.awaddr[6:2];
          wstate_d = W_ADDR;
        end else if (axi.wvalid) begin
          wdata_d  = axi.wdata;
          wstate_d = W_DATA;
        end
      end
      W_ADDR: if (axi.wvalid) begin
        commit   = 1'b1;
        c_data   = axi.wdata;
        wstate_d = W_RESP;
      end
      W_DATA: if (axi.awvalid) begin
        commit   = 1'b1;
        c_addr   = axi.awaddr[6:2];
        wstate_d = W_RESP;
      end
      W_RESP: if (axi.bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge i_fb_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign axi.awready = (wstate_q == W_IDLE) || (wstate_q == W_DATA);
  assign axi.wready  = (wstate_q == W_IDLE) || (wstate_q == W_ADDR);
  assign axi.bvalid  = (wstate_q == W_RESP);

  // ---------------------------------------------------------------- registers
  logic [31:0]      ctrl_q;
  logic [3:0][31:0] gp_q;

  always_ff @(posedge i_fb_clk or negedge i_arstn) begin
    if (!i_arstn)                      ctrl_q <= CTRL_RST;
    else if (commit && c_addr == 5'd0) ctrl_q <= c_data;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gp
      logic [31:0] gp_r_q;
      always_ff @(posedge i_fb_clk or negedge i_arstn) begin
        if (!i_arstn)                           gp_r_q <= '0;
        else if (commit && c_addr == 5'(4 + gi)) gp_r_q <= c_data;
      end
      assign gp_q[gi] = gp_r_q;
    end
  endgenerate

  // ---------------------------------------------------------------- cmd FIFO
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               full, empty, pop, push_req, push_ok;
  logic               ovf_q, ovf_set, ovf_clr, irq_q;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign pop      = !empty && i_cmd_ready;
  assign push_req = commit && (c_addr == 5'd3);
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = commit && (c_addr == 5'd2) && c_data[0];

  always_ff @(posedge i_fb_clk) begin
    if (push_ok) mem[wr_ptr_q] <= c_data;
  end

  always_ff @(posedge i_fb_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_ok && !pop)      level_q <= level_q + LVL_ONE;
      else if (pop && !push_ok) level_q <= level_q - LVL_ONE;
      // Set takes priority over a simultaneous clear.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      irq_q <= ovf_q & ctrl_q[0];
    end
  end

  assign o_cmd_valid = !empty;
  assign o_cmd_data  = empty ? 32'h0 : mem[rd_ptr_q];
  assign o_ctrl      = ctrl_q;
  assign o_irq       = irq_q;

  // ---------------------------------------------------------------- read path
  logic [31:0] status, rd_mux;
  logic [31:0] rdata_q, rdata_d;
  logic [0:0]  rstate_q, rstate_d;

  assign status = {13'd0, ovf_q, empty, full, 11'd0, 5'(level_q)};

  always_comb begin
    rd_mux = '0;
    case (axi.araddr[6:2])
      5'd0:                    rd_mux = ctrl_q;
      5'd1:                    rd_mux = status;
      5'd4, 5'd5, 5'd6, 5'd7:  rd_mux = gp_q[axi.araddr[3:2]];
      default:                 rd_mux = '0;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: if (axi.arvalid) begin
        rdata_d  = rd_mux;   // snapshot of pre-commit register values
        rstate_d = R_DATA;
      end
      default: if (axi.rready) rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_fb_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
    end
  end

  assign axi.arready = (rstate_q == R_IDLE);
  assign axi.rvalid  = (rstate_q == R_DATA);
  assign axi.rdata   = rdata_q;

  // Byte-lane address bits carry no meaning for word registers.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{axi.awaddr[1:0], axi.araddr[1:0]};

endmodule

// File: tb/tb_dsi_cfg_axil_responder.sv
module tb_dsi_cfg_axil_responder;
  logic        i_fb_clk = 1'b0;
  logic        i_arstn  = 1'b0;
  logic [31:0] o_ctrl, o_cmd_data;
  logic        o_cmd_valid, o_irq;
  logic        i_cmd_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;

  dsi_cfg_axil_responder_if axi ();

  dsi_cfg_axil_responder #(.FIFO_AW(4), .CTRL_RST(32'h0)) dut (
    .i_fb_clk    (i_fb_clk),
    .i_arstn     (i_arstn),
    .axi         (axi),
    .o_ctrl      (o_ctrl),
    .o_cmd_data  (o_cmd_data),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ready (i_cmd_ready),
    .o_irq       (o_irq)
  );

  always #5 i_fb_clk = ~i_fb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_fb_clk);
    #1;
  endtask

  task automatic bresp();
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d);
    axi.awaddr = a; axi.wdata = d;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check("wr_bvalid", {31'd0, axi.bvalid}, 32'd1);
    bresp();
    $display("WR addr=%02h data=%08h", a, d);
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
    axi.araddr = a; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    check("rd_rvalid", {31'd0, axi.rvalid}, 32'd1);
    d = axi.rdata;
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    $display("RD addr=%02h data=%08h", a, d);
  endtask

  initial begin
    axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wvalid = 0;
    axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;

    // Reset state
    #3;
    check("rst_awready", {31'd0, axi.awready}, 32'd1);
    check("rst_wready",  {31'd0, axi.wready},  32'd1);
    check("rst_arready", {31'd0, axi.arready}, 32'd1);
    check("rst_bvalid",  {31'd0, axi.bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, axi.rvalid},  32'd0);
    check("rst_rdata",   axi.rdata, 32'd0);
    check("rst_ctrl",    o_ctrl, 32'd0);
    check("rst_cmdv",    {31'd0, o_cmd_valid}, 32'd0);
    check("rst_cmdd",    o_cmd_data, 32'd0);
    check("rst_irq",     {31'd0, o_irq}, 32'd0);
    #9 i_arstn = 1'b1;
    tick();
    axi_read(7'h04, rd); check("rst_status", rd, 32'h0002_0000);

    // 1: AW+W same cycle
    axi_write(7'h10, 32'hA5A5_0001);
    axi_read(7'h10, rd); check("t1_gp0", rd, 32'hA5A5_0001);

    // 2a: AW first, W three cycles later
    axi.awaddr = 7'h14; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    check("t2a_awready", {31'd0, axi.awready}, 32'd0);
    check("t2a_wready",  {31'd0, axi.wready},  32'd1);
    tick(); tick();
    check("t2a_bvalid_wait", {31'd0, axi.bvalid}, 32'd0);
    axi.wdata = 32'h0000_1234; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    check("t2a_bvalid", {31'd0, axi.bvalid}, 32'd1);
    bresp();
    check("t2a_idle_awready", {31'd0, axi.awready}, 32'd1);
    axi_read(7'h14, rd); check("t2a_gp1", rd, 32'h0000_1234);

    // 2b: W first, AW three cycles later
    axi.wdata = 32'h0000_5678; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    check("t2b_awready", {31'd0, axi.awready}, 32'd1);
    check("t2b_wready",  {31'd0, axi.wready},  32'd0);
    tick(); tick();
    axi.awaddr = 7'h18; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    check("t2b_bvalid", {31'd0, axi.bvalid}, 32'd1);
    bresp();
    axi_read(7'h18, rd); check("t2b_gp2", rd, 32'h0000_5678);

    // 3: same-cycle write+read of GP3, then backpressure on both channels
    axi.awaddr = 7'h1C; axi.wdata = 32'hBEEF_0003; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 7'h1C; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    check("t3_prewrite_rdata", axi.rdata, 32'h0);
    repeat (5) tick();
    check("t3_bvalid_held", {31'd0, axi.bvalid},  32'd1);
    check("t3_awready_low", {31'd0, axi.awready}, 32'd0);
    check("t3_wready_low",  {31'd0, axi.wready},  32'd0);
    check("t3_rvalid_held", {31'd0, axi.rvalid},  32'd1);
    check("t3_arready_low", {31'd0, axi.arready}, 32'd0);
    check("t3_rdata_stable", axi.rdata, 32'h0);
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0; axi.rready = 1'b0;
    check("t3_bvalid_done", {31'd0, axi.bvalid}, 32'd0);
    check("t3_rvalid_done", {31'd0, axi.rvalid}, 32'd0);
    axi_read(7'h1C, rd); check("t3_gp3", rd, 32'hBEEF_0003);

    // 4: fill FIFO, overflow, interrupt
    for (int i = 0; i < 16; i++) axi_write(7'h0C, 32'hC000_0000 + 32'(i));
    axi_read(7'h04, rd); check("t4_status_full", rd, 32'h0001_0010);
    check("t4_cmdv", {31'd0, o_cmd_valid}, 32'd1);
    check("t4_head", o_cmd_data, 32'hC000_0000);
    axi_write(7'h0C, 32'hC000_0010);
    axi_read(7'h04, rd); check("t4_status_ovf", rd, 32'h0005_0010);
    check("t4_irq_disabled", {31'd0, o_irq}, 32'd0);
    axi_write(7'h00, 32'h1);
    check("t4_ctrl", o_ctrl, 32'h1);
    check("t4_irq_on", {31'd0, o_irq}, 32'd1);
    axi_write(7'h08, 32'h1);
    check("t4_irq_off", {31'd0, o_irq}, 32'd0);
    axi_read(7'h04, rd); check("t4_status_clr", rd, 32'h0001_0010);

    // 5: push while full with a simultaneous pop
    axi.awaddr = 7'h0C; axi.wdata = 32'hD000_0000; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    i_cmd_ready = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; i_cmd_ready = 1'b0;
    check("t5_bvalid", {31'd0, axi.bvalid}, 32'd1);
    bresp();
    axi_read(7'h04, rd); check("t5_status", rd, 32'h0001_0010);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t5_pop%0d", i), o_cmd_data,
            (i < 15) ? 32'hC000_0001 + 32'(i) : 32'hD000_0000);
      i_cmd_ready = 1'b1;
      tick();
      i_cmd_ready = 1'b0;
    end
    check("t5_empty", {31'd0, o_cmd_valid}, 32'd0);
    i_cmd_ready = 1'b1;
    tick();
    i_cmd_ready = 1'b0;
    axi_read(7'h04, rd); check("t5_pop_empty_status", rd, 32'h0002_0000);

    // 6: unmapped addresses, CMD_PUSH read, reset mid-transaction
    axi_read(7'h7C, rd); check("t6_unmapped_rd", rd, 32'h0);
    axi_read(7'h0C, rd); check("t6_cmdpush_rd", rd, 32'h0);
    axi_write(7'h7C, 32'hFFFF_FFFF);
    axi_read(7'h10, rd); check("t6_gp0", rd, 32'hA5A5_0001);
    axi_read(7'h14, rd); check("t6_gp1", rd, 32'h0000_1234);
    axi_read(7'h18, rd); check("t6_gp2", rd, 32'h0000_5678);
    axi_read(7'h1C, rd); check("t6_gp3", rd, 32'hBEEF_0003);
    axi_write(7'h0C, 32'h0000_0011);
    check("t6_cmdv", {31'd0, o_cmd_valid}, 32'd1);
    axi.awaddr = 7'h10; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    check("t6_waddr_awready", {31'd0, axi.awready}, 32'd0);
    #2 i_arstn = 1'b0;
    #1;
    check("t6_rst_awready", {31'd0, axi.awready}, 32'd1);
    check("t6_rst_wready",  {31'd0, axi.wready},  32'd1);
    check("t6_rst_bvalid",  {31'd0, axi.bvalid},  32'd0);
    check("t6_rst_cmdv",    {31'd0, o_cmd_valid}, 32'd0);
    check("t6_rst_ctrl",    o_ctrl, 32'd0);
    #3 i_arstn = 1'b1;
    tick();
    axi_read(7'h10, rd); check("t6_rst_gp0", rd, 32'h0);
    axi_read(7'h04, rd); check("t6_rst_status", rd, 32'h0002_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
